// File: rtl/scm_readout_streamer.sv
`default_nettype none
// scm_readout_streamer: sweeps a wrap-around range of a registered-read register file
// and presents the entries as a valid/ready/last stream through a 3-entry FIFO.
module scm_readout_streamer #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] StartAddr,
    input  logic [ADDR_WIDTH:0]   Count,
    input  logic                  Clear,
    output logic                  Busy,
    output logic                  Done,
    output logic                  ReadEnable,
    output logic [ADDR_WIDTH-1:0] ReadAddr,
    input  logic [DATA_WIDTH-1:0] ReadData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic                  OutLast
);
    localparam int FIFO_DEPTH = 3;
    localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] hold_q, hold_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  outst_q, outst_d;
    logic                  outst_last_q, outst_last_d;
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;

    logic [ADDR_WIDTH:0]   count_clamped;
    logic [2:0]            inflight;
    logic                  issue;
    logic                  capture;
    logic                  pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign count_clamped = (Count > MAX_COUNT) ? MAX_COUNT : Count;
    // Space is reserved for the read already in flight, so issue never looks at OutReady.
    assign inflight   = {1'b0, occ_q} + {2'b00, outst_q};
    assign issue      = (state_q == S_STREAM) && (remaining_q != '0) && (inflight <= 3'd2);
    assign capture    = outst_q;
    assign OutValid   = (occ_q != 2'd0);
    assign pop        = OutValid && OutReady;
    assign OutData    = fifo_data_q[rd_ptr_q];
    assign OutLast    = fifo_last_q[rd_ptr_q];
    assign ReadEnable = issue;
    assign ReadAddr   = issue ? addr_q : hold_q;
    assign Busy       = (state_q != S_IDLE);
    assign Done       = (state_q == S_DONE);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        hold_d       = hold_q;
        remaining_d  = remaining_q;
        outst_d      = issue;
        outst_last_d = issue && (remaining_q == (ADDR_WIDTH+1)'(1));
        wr_ptr_d     = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d        = occ_q + {1'b0, capture} - {1'b0, pop};

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    addr_d      = StartAddr;
                    remaining_d = count_clamped;
                    state_d     = (count_clamped == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                if (issue) begin
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    hold_d      = addr_q;
                    remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
                end
                if (pop && OutLast) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (Clear) begin
            state_d      = S_IDLE;
            addr_d       = '0;
            remaining_d  = '0;
            outst_d      = 1'b0;
            outst_last_d = 1'b0;
            wr_ptr_d     = 2'd0;
            rd_ptr_d     = 2'd0;
            occ_d        = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            hold_q       <= '0;
            remaining_q  <= '0;
            outst_q      <= 1'b0;
            outst_last_q <= 1'b0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            occ_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            hold_q       <= hold_d;
            remaining_q  <= remaining_d;
            outst_q      <= outst_d;
            outst_last_q <= outst_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q <= '0;
        end else if (capture && !Clear) begin
            fifo_data_q[wr_ptr_q] <= ReadData;
            fifo_last_q[wr_ptr_q] <= outst_last_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scm_readout_streamer.sv
`default_nettype none
// Bench for scm_readout_streamer: random memory and commands, beats checked against an
// address-range model and an in-flight-count flow model.
module tb_scm_readout_streamer;
    localparam int AW    = 5;
    localparam int DW    = 64;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Start;
    logic [AW-1:0] StartAddr;
    logic [AW:0]   Count;
    logic          Clear;
    logic          Busy;
    logic          Done;
    logic          ReadEnable;
    logic [AW-1:0] ReadAddr;
    logic [DW-1:0] ReadData = '0;
    logic          OutValid;
    logic          OutReady;
    logic [DW-1:0] OutData;
    logic          OutLast;

    logic [DW-1:0] mem [DEPTH];
    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] b_data[$];
    logic          b_last[$];
    int            b_cyc[$];
    logic [AW-1:0] re_addr[$];
    int            re_cyc[$];
    int            done_cyc[$];
    int            flow_err;
    int            stab_err;

    scm_readout_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .StartAddr(StartAddr), .Count(Count),
        .Clear(Clear), .Busy(Busy), .Done(Done), .ReadEnable(ReadEnable),
        .ReadAddr(ReadAddr), .ReadData(ReadData), .OutValid(OutValid),
        .OutReady(OutReady), .OutData(OutData), .OutLast(OutLast)
    );

    always #5 clk = ~clk;

    // Registered-read register file.
    always @(posedge clk) begin
        if (ReadEnable) ReadData <= mem[ReadAddr];
    end

    task automatic fill_random;
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    endtask

    // Runs one command; cycle 0 is the Start cycle. mode 0: ready=1, 1: 1,0,0 pattern, 2: random.
    task automatic run_cmd(input logic [AW-1:0] a, input logic [AW:0] c, input int mode, input bit hold);
        int cc, issued, popped, captured, stop_k;
        bit last_hs, done_prev, pv, pr, exp_re, exp_valid, exp_busy;
        logic [DW-1:0] pd;
        logic pl;
        cc = (int'(c) > DEPTH) ? DEPTH : int'(c);
        b_data.delete(); b_last.delete(); b_cyc.delete();
        re_addr.delete(); re_cyc.delete(); done_cyc.delete();
        flow_err = 0; stab_err = 0;
        issued = 0; popped = 0; last_hs = 0; done_prev = 0; pv = 0; pr = 0;
        pd = '0; pl = 1'b0; stop_k = -1;
        @(negedge clk);
        Start = 1'b1; StartAddr = a; Count = c;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1 && !hold) Start = 1'b0;
            case (mode)
                0:       OutReady = 1'b1;
                1:       OutReady = (k % 3 == 0);
                default: OutReady = 1'($urandom_range(0, 1));
            endcase
            captured = 0;
            foreach (re_cyc[j]) if (re_cyc[j] <= k - 2) captured++;
            exp_re    = (k >= 1) && (cc > 0) && !last_hs && (cc - issued > 0) && (issued - popped <= 2);
            exp_valid = (captured - popped) > 0;
            exp_busy  = (k >= 1) && !done_prev;
            if (ReadEnable !== exp_re || OutValid !== exp_valid || Busy !== exp_busy) flow_err++;
            if (pv && !pr && (OutValid !== 1'b1 || OutData !== pd || OutLast !== pl)) stab_err++;
            if (ReadEnable) begin
                re_addr.push_back(ReadAddr); re_cyc.push_back(k); issued++;
            end
            if (OutValid && OutReady) begin
                b_data.push_back(OutData); b_last.push_back(OutLast); b_cyc.push_back(k);
                popped++;
                if (OutLast) last_hs = 1'b1;
            end
            if (Done) begin
                done_cyc.push_back(k);
                if (stop_k < 0) stop_k = k + 2;
                Start = 1'b0;
                done_prev = 1'b1;
            end
            pv = OutValid; pr = OutReady; pd = OutData; pl = OutLast;
            if (k == stop_k) break;
        end
        Start = 1'b0;
    endtask

    task automatic test_stream(input logic [AW-1:0] a, input logic [AW:0] c, input int mode,
                               input bit hold, input string name);
        int cc, errs, aerrs, exp_done;
        logic [AW-1:0] ea;
        cc = (int'(c) > DEPTH) ? DEPTH : int'(c);
        run_cmd(a, c, mode, hold);
        n_checks++;
        if (b_data.size() !== cc) $display("FAIL %s beat_count: got %0d expected %0d", name, b_data.size(), cc);
        else n_pass++;
        errs = 0;
        for (int i = 0; i < b_data.size() && i < cc; i++) begin
            ea = a + AW'(i);
            if (b_data[i] !== mem[ea] || b_last[i] !== (i == cc - 1)) errs++;
            if (mode == 0 && b_cyc[i] !== 3 + i) errs++;
        end
        n_checks++;
        if (errs !== 0) $display("FAIL %s beat_content: %0d bad beats, expected 0", name, errs);
        else n_pass++;
        aerrs = (re_addr.size() == cc) ? 0 : 1;
        for (int i = 0; i < re_addr.size() && i < cc; i++) begin
            ea = a + AW'(i);
            if (re_addr[i] !== ea) aerrs++;
        end
        n_checks++;
        if (aerrs !== 0) $display("FAIL %s read_addrs: %0d errors (issued %0d) expected %0d reads", name, aerrs, re_addr.size(), cc);
        else n_pass++;
        n_checks++;
        if (flow_err !== 0) $display("FAIL %s flow: %0d cycles with wrong ReadEnable/OutValid/Busy, expected 0", name, flow_err);
        else n_pass++;
        n_checks++;
        if (stab_err !== 0) $display("FAIL %s stability: %0d unstable stalled beats, expected 0", name, stab_err);
        else n_pass++;
        n_checks++;
        if (done_cyc.size() !== 1) $display("FAIL %s done_pulses: got %0d expected 1", name, done_cyc.size());
        else n_pass++;
        if (mode == 0 && done_cyc.size() > 0) begin
            exp_done = (cc == 0) ? 1 : cc + 3;
            n_checks++;
            if (done_cyc[0] !== exp_done) $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc[0], exp_done);
            else n_pass++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({Busy, Done, ReadEnable, OutValid, OutLast} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000", {Busy, Done, ReadEnable, OutValid, OutLast});
        else n_pass++;
        n_checks++;
        if (ReadAddr !== '0) $display("FAIL reset_addr: got %0d expected 0", ReadAddr);
        else n_pass++;
        n_checks++;
        if (OutData !== '0) $display("FAIL reset_data: got %h expected 0", OutData);
        else n_pass++;
    endtask

    task automatic test_basic;
        logic [DW-1:0] exp_v [3];
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i) * 64'h11;
        exp_v[0] = 64'h44; exp_v[1] = 64'h55; exp_v[2] = 64'h66;
        test_stream(5'd4, 6'd3, 0, 1'b0, "basic");
        for (int i = 0; i < 3 && i < b_data.size(); i++) begin
            n_checks++;
            if (b_data[i] !== exp_v[i]) $display("FAIL basic_value%0d: got %h expected %h", i, b_data[i], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap;
        fill_random();
        test_stream(5'd30, 6'd4, 0, 1'b0, "wrap");
    endtask

    task automatic test_full_sweep;
        int nlast;
        fill_random();
        test_stream(AW'($urandom), 6'd32, 0, 1'b0, "full");
        nlast = 0;
        foreach (b_last[i]) if (b_last[i]) nlast++;
        n_checks++;
        if (nlast !== 1) $display("FAIL full_last_count: got %0d expected 1", nlast);
        else n_pass++;
    endtask

    task automatic test_clamp;
        fill_random();
        test_stream(AW'($urandom), 6'd45, 0, 1'b0, "clamp");
    endtask

    task automatic test_count_zero;
        test_stream(AW'($urandom), 6'd0, 0, 1'b0, "count0");
    endtask

    task automatic test_backpressure;
        int span;
        fill_random();
        test_stream(AW'($urandom), 6'd8, 1, 1'b0, "backpressure");
        span = (re_cyc.size() > 0) ? re_cyc[re_cyc.size() - 1] - re_cyc[0] : 0;
        n_checks++;
        if (span <= 7) $display("FAIL backpressure_stall: issue span %0d cycles, expected more than 7", span);
        else n_pass++;
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            fill_random();
            test_stream(AW'($urandom), 6'($urandom_range(1, 32)), 2, 1'b0, "random");
        end
    endtask

    task automatic test_hold_start;
        fill_random();
        test_stream(AW'($urandom), 6'd5, 0, 1'b1, "hold_start");
    endtask

    task automatic test_clear;
        int bad;
        fill_random();
        OutReady = 1'b0;
        @(negedge clk); Start = 1'b1; StartAddr = AW'($urandom); Count = 6'd8;
        @(negedge clk); Start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (OutValid !== 1'b1 || ReadEnable !== 1'b0)
            $display("FAIL clear_pre: OutValid=%b ReadEnable=%b expected 1 0", OutValid, ReadEnable);
        else n_pass++;
        Clear = 1'b1;
        @(negedge clk); Clear = 1'b0;
        n_checks++;
        if ({OutValid, Busy, Done} !== 3'b000)
            $display("FAIL clear_effect: OutValid/Busy/Done=%b expected 000", {OutValid, Busy, Done});
        else n_pass++;
        Clear = 1'b1; Start = 1'b1;
        @(negedge clk); Clear = 1'b0; Start = 1'b0;
        n_checks++;
        if (Busy !== 1'b0) $display("FAIL clear_over_start: Busy=%b expected 0", Busy);
        else n_pass++;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (Done || OutValid || ReadEnable || Busy) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL clear_quiet: %0d active cycles, expected 0", bad);
        else n_pass++;
        test_stream(AW'($urandom), 6'd2, 0, 1'b0, "after_clear");
    endtask

    task automatic test_reset_mid;
        int bad;
        fill_random();
        OutReady = 1'b1;
        @(negedge clk); Start = 1'b1; StartAddr = AW'($urandom); Count = 6'd10;
        @(negedge clk); Start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({Busy, Done, ReadEnable, OutValid, OutLast} !== 5'b0)
            $display("FAIL rstmid_ctrl: got %b expected 00000", {Busy, Done, ReadEnable, OutValid, OutLast});
        else n_pass++;
        n_checks++;
        if (ReadAddr !== '0 || OutData !== '0)
            $display("FAIL rstmid_data: ReadAddr=%0d OutData=%h expected 0 0", ReadAddr, OutData);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (OutValid || ReadEnable || Busy || Done) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL rstmid_quiet: %0d active cycles after release, expected 0", bad);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; Start = 1'b0; StartAddr = '0; Count = '0; Clear = 1'b0; OutReady = 1'b0;
        fill_random();
        test_reset();
        test_basic();
        test_wrap();
        test_full_sweep();
        test_clamp();
        test_count_zero();
        test_backpressure();
        test_random();
        test_hold_start();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
